beep_player: RTL and testbench
==============================

// Module: beep_player
// PURPOSE
//  Note sequencer for the buzzer path. Accepts (period, length) notes over a valid/ready stream,
//  programs the loop timer, reads its live count back, and drives a square-wave buzzer pin.
//  Sits between a melody source (ROM/UART) and the count/flag timer.
//  Counts length in ticks of TICK_DIV clocks, then inserts a silent gap between notes.
// PARAMETERS
//  TICK_DIV    50000  clk cycles per duration tick (1 ms at 50 MHz); must be >= 1
//  GAP_TICKS   20     silent ticks after each note; 0 = no gap
//  DUTY_SHIFT  1      beep high while tmr_cnt_now < (period >> DUTY_SHIFT); 1 = 50 %
// PORTS
//  clk             in   1   system clock
//  rst             in   1   synchronous reset, active-high
//  note_valid      in   1   note on note_period/note_len/note_last is valid
//  note_ready      out  1   player can accept a note
//  note_period     in   32  timer period in clk cycles; < 2 = rest (silent note)
//  note_len        in   16  note duration in ticks
//  note_last       in   1   final note of melody
//  tmr_cnt_default out  32  period programmed into timer
//  tmr_mode        out  1   timer mode; held 1 (loop mode)
//  tmr_ena         out  1   timer run control; timer counts while 0, held/cleared while 1
//  tmr_cnt_now     in   32  live timer count
//  tmr_flag        in   1   timer period-wrap flag (counts completed periods only)
//  beep            out  1   buzzer drive, registered
//  busy            out  1   high in PLAY or GAP
//  done            out  1   1-cycle pulse after GAP of a note_last note
// BEHAVIOUR
//  Reset: IDLE; note_ready=0 for the reset cycle, then 1; tmr_cnt_default=0; tmr_mode=1;
//   tmr_ena=1; beep=0; busy=0; done=0; prescaler, tick count, latched note cleared.
//  Handshake: transfer on clk edge with note_valid & note_ready. note_ready=1 only in IDLE.
//   Fields latched on transfer; later input changes are ignored until next IDLE.
//  FSM IDLE -> PLAY on transfer (note_len>0); IDLE -> GAP on transfer with note_len=0.
//   PLAY -> GAP when tick count reaches note_len.
//   GAP -> IDLE when tick count reaches GAP_TICKS (immediately if GAP_TICKS=0).
//   GAP exit with latched note_last=1: done pulses 1 cycle, same cycle as IDLE entry.
//  PLAY: tmr_cnt_default=latched period; tmr_ena=0. Other states: tmr_ena=1, default kept.
//  Ticks: prescaler 0..TICK_DIV-1, cleared on every state entry. Tick count increments on wrap.
//   PLAY lasts exactly note_len*TICK_DIV cycles; GAP lasts GAP_TICKS*TICK_DIV cycles.
//  beep(n+1) = PLAY & period>=2 & (tmr_cnt_now < period>>DUTY_SHIFT); 1-cycle registered latency.
//   Rest notes still occupy full PLAY time with beep=0.
//  Width rules: period compare is unsigned 32-bit; tick count is 16-bit and never wraps
//   (compare stops it). Shifted threshold 0 forces beep=0.
//  Simultaneous: note_valid during PLAY/GAP is not accepted (ready=0); source must hold it.
//   tmr_flag is not used for sequencing.
//  Reset mid-note: beep drops to 0 next edge; tmr_ena=1; the note is discarded, no done pulse.
// CONFIGURATION
//  BEEP_PLAYER_VOLUME_EN defined: extra input duty_sel[1:0] adds a runtime shift of 1+duty_sel
//   (25/12.5/6.25 % steps). duty_sel is latched with each note; DUTY_SHIFT is ignored.
//  Not defined: no duty_sel port; fixed DUTY_SHIFT.
// TESTING (bench: TICK_DIV=10, GAP_TICKS=2, DUTY_SHIFT=1, behavioural loop timer)
//  1. Reset: rst=1 for 3 cycles -> beep=0, tmr_ena=1, tmr_mode=1, busy=0; note_ready=1 1 cycle after release.
//  2. Note period=8, len=3, last=1 -> 30 PLAY cycles; beep high 4 / low 4 clocks;
//     then 20 GAP cycles with beep=0; done pulses once; note_ready returns to 1.
//  3. Rest period=0, len=2 -> busy 40 cycles; beep never 1; tmr_cnt_default=0.
//  4. Back-to-back notes: note_valid held high, two notes (period 8 then 12) -> second accepted
//     first IDLE cycle after gap; beep period switches 8 -> 12; done only after second note.
//  5. Reset mid-PLAY (cycle 15 of note 2) -> next edge beep=0, tmr_ena=1, IDLE, no done.
//  6. note_len=0, last=1 -> straight to GAP: 20 cycles, beep=0, then done.
//     With BEEP_PLAYER_VOLUME_EN, duty_sel=1, period=16 -> beep high 4 of 16.

Source files
------------

// File: rtl/beep_player.sv
// Note sequencer for the buzzer path: plays (period, length) notes via a loop timer.
// Optional runtime duty select enabled by defining BEEP_PLAYER_VOLUME_EN.
module beep_player #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned GAP_TICKS  = 20,
    parameter int unsigned DUTY_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [31:0] note_period,
    input  logic [15:0] note_len,
    input  logic        note_last,
`ifdef BEEP_PLAYER_VOLUME_EN
    input  logic [1:0]  duty_sel,
`endif
    output logic [31:0] tmr_cnt_default,
    output logic        tmr_mode,
    output logic        tmr_ena,
    input  logic [31:0] tmr_cnt_now,
    input  logic        tmr_flag,
    output logic        beep,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST_PRE = PW'(TICK_DIV - 1);
    localparam logic [15:0] GAP_T = 16'(GAP_TICKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] pre;
    logic [15:0]   ticks;
    logic [31:0]   per;
    logic [15:0]   len;
    logic          last;
    logic [31:0]   thr;
    logic          beep_on;
    logic          unused_flag;

    // The timer wrap flag carries no sequencing information here.
    assign unused_flag = tmr_flag;

`ifdef BEEP_PLAYER_VOLUME_EN
    logic [1:0] duty_q;

    // High-time threshold from the per-note duty selection.
    always_comb begin
        thr = per >> ({1'b0, duty_q} + 3'd1);
        beep_on = (per >= 32'd2) && (tmr_cnt_now < thr);
    end
`else
    // High-time threshold from the fixed duty shift.
    always_comb begin
        thr = per >> DUTY_SHIFT;
        beep_on = (per >= 32'd2) && (tmr_cnt_now < thr);
    end
`endif

    // Note FSM with tick prescaler and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            note_ready      <= 1'b0;
            tmr_cnt_default <= 32'd0;
            tmr_mode        <= 1'b1;
            tmr_ena         <= 1'b1;
            beep            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pre             <= '0;
            ticks           <= 16'd0;
            per             <= 32'd0;
            len             <= 16'd0;
            last            <= 1'b0;
`ifdef BEEP_PLAYER_VOLUME_EN
            duty_q          <= 2'd0;
`endif
        end else begin
            tmr_mode <= 1'b1;
            done     <= 1'b0;
            beep     <= (state == PLAY) && beep_on;
            unique case (state)
                IDLE: begin
                    note_ready <= 1'b1;
                    if (note_valid && note_ready) begin
                        per   <= note_period;
                        len   <= note_len;
                        last  <= note_last;
                        pre   <= '0;
                        ticks <= 16'd0;
`ifdef BEEP_PLAYER_VOLUME_EN
                        duty_q <= duty_sel;
`endif
                        if (note_len != 16'd0) begin
                            state           <= PLAY;
                            note_ready      <= 1'b0;
                            busy            <= 1'b1;
                            tmr_ena         <= 1'b0;
                            tmr_cnt_default <= note_period;
                        end else if (GAP_T != 16'd0) begin
                            state      <= GAP;
                            note_ready <= 1'b0;
                            busy       <= 1'b1;
                        end else begin
                            done <= note_last;
                        end
                    end
                end
                PLAY: begin
                    if (pre == LAST_PRE) begin
                        pre <= '0;
                        if (ticks + 16'd1 == len) begin
                            ticks   <= 16'd0;
                            tmr_ena <= 1'b1;
                            if (GAP_T != 16'd0) begin
                                state <= GAP;
                            end else begin
                                state      <= IDLE;
                                busy       <= 1'b0;
                                done       <= last;
                                note_ready <= 1'b1;
                            end
                        end else begin
                            ticks <= ticks + 16'd1;
                        end
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
                GAP: begin
                    if (pre == LAST_PRE) begin
                        pre <= '0;
                        if (ticks + 16'd1 == GAP_T) begin
                            ticks      <= 16'd0;
                            state      <= IDLE;
                            busy       <= 1'b0;
                            done       <= last;
                            note_ready <= 1'b1;
                        end else begin
                            ticks <= ticks + 16'd1;
                        end
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beep_player.sv
// Bench for beep_player with a behavioural loop timer.
// Per-note scoreboard of busy length, beep high count and done pulse.
module tb_beep_player;

    localparam int TD = 10;
    localparam int GT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        note_valid = 1'b0;
    logic        note_ready;
    logic [31:0] note_period = 32'd0;
    logic [15:0] note_len = 16'd0;
    logic        note_last = 1'b0;
`ifdef BEEP_PLAYER_VOLUME_EN
    logic [1:0]  duty_sel = 2'd0;
`endif
    logic [31:0] tmr_cnt_default;
    logic        tmr_mode;
    logic        tmr_ena;
    logic [31:0] tmr_cnt_now = 32'd0;
    logic        tmr_flag = 1'b0;
    logic        beep;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    typedef struct {
        int busy_cyc;
        int highs;
        int done_exp;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [31:0] period;
        logic [15:0] len;
        logic        last;
        bit          drop;
        int          wait_exp;
        int          busy_cyc;
        int          highs;
        int          done_exp;
    } vec_t;

    vec_t tbl[5];

    beep_player #(
        .TICK_DIV(TD),
        .GAP_TICKS(GT),
        .DUTY_SHIFT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note_period(note_period),
        .note_len(note_len),
        .note_last(note_last),
`ifdef BEEP_PLAYER_VOLUME_EN
        .duty_sel(duty_sel),
`endif
        .tmr_cnt_default(tmr_cnt_default),
        .tmr_mode(tmr_mode),
        .tmr_ena(tmr_ena),
        .tmr_cnt_now(tmr_cnt_now),
        .tmr_flag(tmr_flag),
        .beep(beep),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Loop timer: held at 0 while ena=1, counts 0..default-1 while ena=0.
    always @(posedge clk) begin
        if (tmr_ena) begin
            tmr_cnt_now <= 32'd0;
            tmr_flag    <= 1'b0;
        end else if (tmr_cnt_now + 32'd1 >= tmr_cnt_default) begin
            tmr_cnt_now <= 32'd0;
            tmr_flag    <= 1'b1;
        end else begin
            tmr_cnt_now <= tmr_cnt_now + 32'd1;
            tmr_flag    <= 1'b0;
        end
    end

    function automatic void check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endfunction

    bit in_note = 1'b0;
    int cyc = 0;
    int highs = 0;

    // Measure each busy window and compare it against the next expectation.
    always @(negedge clk) begin
        if (rst) begin
            in_note = 1'b0;
        end else if (busy) begin
            if (!in_note) begin
                in_note = 1'b1;
                cyc = 0;
                highs = 0;
            end
            cyc++;
            if (beep) highs++;
            check("done_in_busy", done, 0);
        end else begin
            if (in_note) begin
                in_note = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_note_end", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("busy_cycles", cyc, e.busy_cyc);
                    check("beep_highs", highs, e.highs);
                    check("done_pulse", done, e.done_exp);
                end
            end else begin
                check("done_idle", done, 0);
            end
            check("beep_idle", beep, 0);
        end
    end

    task automatic send(input vec_t v, input bit push);
        int waited;
        exp_t e;
        note_valid  = 1'b1;
        note_period = v.period;
        note_len    = v.len;
        note_last   = v.last;
        waited = 0;
        while (!note_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!note_ready) begin
            check("ready_timeout", waited, v.wait_exp);
            note_valid = 1'b0;
            return;
        end
        check("accept_wait", waited, v.wait_exp);
        if (push) begin
            e.busy_cyc = v.busy_cyc;
            e.highs    = v.highs;
            e.done_exp = v.done_exp;
            sb.push_back(e);
        end
        @(negedge clk);
        if (v.drop) note_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{32'd8,  16'd3, 1'b1, 1'b1, 0,  50, 16, 1};
        tbl[1] = '{32'd0,  16'd2, 1'b1, 1'b1, 0,  40, 0,  1};
        tbl[2] = '{32'd8,  16'd3, 1'b0, 1'b0, 0,  50, 16, 0};
        tbl[3] = '{32'd12, 16'd3, 1'b1, 1'b1, 50, 50, 18, 1};
        tbl[4] = '{32'd8,  16'd0, 1'b1, 1'b1, 0,  20, 0,  1};

        repeat (3) @(negedge clk);
        check("rst_beep", beep, 0);
        check("rst_ena", tmr_ena, 1);
        check("rst_mode", tmr_mode, 1);
        check("rst_busy", busy, 0);
        check("rst_default", tmr_cnt_default, 0);
        check("rst_ready", note_ready, 0);
        rst = 1'b0;
        check("ready_release", note_ready, 0);
        @(negedge clk);
        check("ready_after", note_ready, 1);

        for (int i = 0; i < 5; i++) begin
            send(tbl[i], 1'b1);
            check("busy_start", busy, 1);
            check("ready_low", note_ready, 0);
            check("ena_state", tmr_ena, (tbl[i].len == 16'd0) ? 1 : 0);
            if (tbl[i].len != 16'd0)
                check("tmr_default", tmr_cnt_default, tbl[i].period);
            if (tbl[i].drop) wait_idle();
        end

        v = '{32'd12, 16'd3, 1'b1, 1'b1, 0, 0, 0, 0};
        send(v, 1'b0);
        repeat (15) @(negedge clk);
        check("pre_rst_beep", beep, 1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_beep", beep, 0);
        check("midrst_ena", tmr_ena, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", note_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_back", note_ready, 1);
        repeat (3) @(negedge clk);

`ifdef BEEP_PLAYER_VOLUME_EN
        duty_sel = 2'd1;
        v = '{32'd16, 16'd2, 1'b1, 1'b1, 0, 40, 8, 1};
        send(v, 1'b1);
        wait_idle();
        duty_sel = 2'd0;
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
